// File: rtl/noc_flit_injector.sv
// noc_flit_injector
// Endpoint-side transmitter for a credit-based NoC router input port.
// Accepts packets from a local valid/ready stream, locks the destination for
// the whole packet (wormhole), tracks downstream buffer space with a credit
// counter and silently discards packets addressed to nonexistent endpoints.
// Flit fields toward the router are registered: a flit accepted in cycle N
// appears with send_out=1 in cycle N+1.

module noc_flit_injector #(
  parameter int NUM_ENDPOINTS     = 4,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2,
  localparam int CNT_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [CNT_WIDTH-1:0]  credit_count,
  output logic                  dest_err,
  output logic                  credit_err
);

  // Packet-level state: waiting for a head, forwarding a body, or discarding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Extended-width constants so comparisons never wrap or truncate.
  localparam logic [DEST_WIDTH:0]  NUM_EP_EXT = (DEST_WIDTH + 1)'(NUM_ENDPOINTS);
  localparam logic [CNT_WIDTH:0]   DEPTH_EXT  = (CNT_WIDTH + 1)'(FLIT_BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT  = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

  state_e                  state_q;
  state_e                  state_d;
  logic [CNT_WIDTH-1:0]    credit_q;
  logic [CNT_WIDTH-1:0]    credit_d;
  logic [CNT_WIDTH:0]      credit_sum_s;
  logic                    credit_err_q;
  logic                    credit_err_d;
  logic                    dest_err_q;
  logic                    dest_err_d;
  logic                    send_q;
  logic                    send_d;
  logic [FLIT_WIDTH-1:0]   data_q;
  logic [FLIT_WIDTH-1:0]   data_d;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [DEST_WIDTH-1:0]   dest_d;
  logic                    tail_q;
  logic                    tail_d;

  logic                    dest_ok_s;
  logic                    have_credit_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    send_s;
  logic                    drop_head_s;

  // A head destination is routable only if it names an existing endpoint.
  assign dest_ok_s     = ({1'b0, in_dest} < NUM_EP_EXT);
  assign have_credit_s = (credit_q != {CNT_WIDTH{1'b0}});
  assign accept_s      = in_valid & in_ready_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: packet boundaries are marked by accepted in_last flits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !in_last) begin
          if (dest_ok_s) begin
            state_d = ST_BODY;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BODY: begin
        if (accept_s && in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BODY;
        end
      end
      ST_DROP: begin
        if (accept_s && in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: ready depends only on registered state plus in_dest, so a
  // credit arriving this cycle cannot raise ready until the next cycle.
  always_comb begin
    in_ready_s  = 1'b0;
    send_s      = 1'b0;
    drop_head_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dest_ok_s) begin
          in_ready_s = have_credit_s;
        end else begin
          in_ready_s = 1'b1;
        end
        send_s      = in_valid & in_ready_s & dest_ok_s;
        drop_head_s = in_valid & in_ready_s & ~dest_ok_s;
      end
      ST_BODY: begin
        in_ready_s = have_credit_s;
        send_s     = in_valid & have_credit_s;
      end
      ST_DROP: begin
        in_ready_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Credit bookkeeping: a send consumes one credit, a return adds one; an
  // excess return saturates at the buffer depth and is flagged.
  always_comb begin
    credit_sum_s = {1'b0, credit_q}
                 + {{CNT_WIDTH{1'b0}}, credit_in}
                 - {{CNT_WIDTH{1'b0}}, send_s};
    if (credit_sum_s > DEPTH_EXT) begin
      credit_d     = DEPTH_CNT;
      credit_err_d = 1'b1;
    end else begin
      credit_d     = credit_sum_s[CNT_WIDTH-1:0];
      credit_err_d = 1'b0;
    end
  end

  // Flit fields toward the router: load on send, otherwise hold. The head
  // flit loads the destination, body flits reuse the locked value.
  always_comb begin
    send_d     = send_s;
    dest_err_d = drop_head_s;
    if (send_s) begin
      data_d = in_data;
      tail_d = in_last;
      if (state_q == ST_IDLE) begin
        dest_d = in_dest;
      end else begin
        dest_d = dest_q;
      end
    end else begin
      data_d = data_q;
      tail_d = tail_q;
      dest_d = dest_q;
    end
  end

  // Credit counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q     <= DEPTH_CNT;
      credit_err_q <= 1'b0;
      dest_err_q   <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      dest_err_q   <= dest_err_d;
    end
  end

  // Registered router-side flit interface.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      send_q <= 1'b0;
      data_q <= {FLIT_WIDTH{1'b0}};
      dest_q <= {DEST_WIDTH{1'b0}};
      tail_q <= 1'b0;
    end else begin
      send_q <= send_d;
      data_q <= data_d;
      dest_q <= dest_d;
      tail_q <= tail_d;
    end
  end

  assign in_ready     = in_ready_s;
  assign send_out     = send_q;
  assign data_out     = data_q;
  assign dest_out     = dest_q;
  assign is_tail_out  = tail_q;
  assign credit_count = credit_q;
  assign dest_err     = dest_err_q;
  assign credit_err   = credit_err_q;

endmodule
